alu_share_arb: RTL and testbench

Two-port arbiter and sequencer for the shared 32-bit ALU. Two requesters (port 0: main datapath issue, port 1: secondary/address-compute issue) submit ALU operations over valid/ready handshakes. The block grants them round-robin, latches the operands, drives one internally instantiated ALU, registers the result and Zero flag, and returns them tagged with the requester id. It sits between the issue logic and the ALU and is the only instantiator of the ALU in the datapath.

---
 rtl/alu_share_arb.sv | 130 +++++++++++++
 tb/tb_alu_share_arb.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin two-port front end for the shared 32-bit ALU: grant, latch operands, execute, return tagged result.
// Optional macro ALU_SHARE_ILLEGAL_CHK_EN enables the illegal control code flag on rsp_err_o.
module alu_share_arb #(
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req0_valid_i,
   output logic          req0_ready_o,
   input  logic [3:0]    req0_ctl_i,
   input  logic [DW-1:0] req0_a_i,
   input  logic [DW-1:0] req0_b_i,
   input  logic          req1_valid_i,
   output logic          req1_ready_o,
   input  logic [3:0]    req1_ctl_i,
   input  logic [DW-1:0] req1_a_i,
   input  logic [DW-1:0] req1_b_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic          rsp_id_o,
   output logic [DW-1:0] rsp_data_o,
   output logic          rsp_zero_o,
   output logic          rsp_err_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    r_state;
   logic          r_last;
   logic [3:0]    r_ctl;
   logic [DW-1:0] r_a;
   logic [DW-1:0] r_b;
   logic          r_id;
   logic [DW-1:0] r_data;
   logic          r_zero;

   logic          w_idle;
   logic          w_grant1;
   logic          w_accept;
   logic [DW-1:0] w_alu;

   // Port 1 wins when it is alone, or on a tie when port 0 was served last.
   assign w_idle       = (r_state == IDLE);
   assign w_grant1     = req1_valid_i && (!req0_valid_i || !r_last);
   assign w_accept     = w_idle && (req0_valid_i || req1_valid_i);
   assign req0_ready_o = w_idle && req0_valid_i && !w_grant1;
   assign req1_ready_o = w_idle && w_grant1;

   assign rsp_valid_o  = (r_state == RESP);
   assign rsp_id_o     = r_id;
   assign rsp_data_o   = r_data;
   assign rsp_zero_o   = r_zero;

   always_comb begin
      w_alu = '0;
      case (r_ctl)
         4'd0:    w_alu = r_a & r_b;
         4'd1:    w_alu = r_a | r_b;
         4'd2:    w_alu = r_a + r_b;
         4'd3:    w_alu = r_b >> r_a;
         4'd5:    w_alu = r_b << 16;
         4'd6:    w_alu = r_a - r_b;
         4'd7:    w_alu = {{(DW-1){1'b0}}, (r_a < r_b)};
         4'd8:    w_alu = r_a | {{(DW-16){1'b0}}, r_b[15:0]};
         4'd10:   w_alu = r_a * r_b;
         default: w_alu = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_ctl   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_id    <= 1'b0;
         r_data  <= '0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_ctl   <= w_grant1 ? req1_ctl_i : req0_ctl_i;
                  r_a     <= w_grant1 ? req1_a_i   : req0_a_i;
                  r_b     <= w_grant1 ? req1_b_i   : req0_b_i;
                  r_id    <= w_grant1;
                  r_last  <= w_grant1;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_data  <= w_alu;
               r_zero  <= (w_alu == '0);
               r_state <= RESP;
            end
            RESP: begin
               if (rsp_ready_i) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SHARE_ILLEGAL_CHK_EN
   logic r_err;
   logic w_illegal;

   assign w_illegal = (r_ctl == 4'd4) || (r_ctl == 4'd9) || (r_ctl >= 4'd11);
   assign rsp_err_o = r_err;

   // The flag lives from the execute edge until the next accepted request.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if (r_state == EXEC) begin
         r_err <= w_illegal;
      end
   end
`else
   assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus randomized traffic against a reference model.
module tb_alu_share_arb;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req0_valid_i, req1_valid_i;
   logic        req0_ready_o, req1_ready_o;
   logic [3:0]  req0_ctl_i, req1_ctl_i;
   logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o, rsp_err_o;
   logic [31:0] rsp_data_o;

   int  nCompared = 0;
   int  nMismatched = 0;
   bit  mLast = 1'b1;

`ifdef ALU_SHARE_ILLEGAL_CHK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   alu_share_arb dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req0_valid_i (req0_valid_i),
      .req0_ready_o (req0_ready_o),
      .req0_ctl_i   (req0_ctl_i),
      .req0_a_i     (req0_a_i),
      .req0_b_i     (req0_b_i),
      .req1_valid_i (req1_valid_i),
      .req1_ready_o (req1_ready_o),
      .req1_ctl_i   (req1_ctl_i),
      .req1_a_i     (req1_a_i),
      .req1_b_i     (req1_b_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_id_o     (rsp_id_o),
      .rsp_data_o   (rsp_data_o),
      .rsp_zero_o   (rsp_zero_o),
      .rsp_err_o    (rsp_err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference ALU written from the operation table with wide arithmetic.
   function automatic logic [31:0] refAlu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] t;
      t = 64'd0;
      case (c)
         4'd0:  t = {32'd0, a & b};
         4'd1:  t = {32'd0, a | b};
         4'd2:  t = 64'(a) + 64'(b);
         4'd3:  t = (a >= 32) ? 64'd0 : 64'(b / (32'd1 << a[4:0]));
         4'd5:  t = 64'(b) * 64'd65536;
         4'd6:  t = 64'(a) + 64'h1_0000_0000 - 64'(b);
         4'd7:  t = (a < b) ? 64'd1 : 64'd0;
         4'd8:  t = {32'd0, a | (b & 32'h0000FFFF)};
         4'd10: t = 64'(a) * 64'(b);
         default: t = 64'd0;
      endcase
      return t[31:0];
   endfunction

   function automatic bit isIllegal(input logic [3:0] c);
      return (c == 4'd4) || (c == 4'd9) || (c >= 4'd11);
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drives one request on a single port and returns the response; no checking here.
   task automatic issue(input bit port, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        output bit ok, output int lat, output logic [31:0] d, output logic z,
                        output logic id, output logic e);
      int n;
      ok = 1'b1;
      rsp_ready_i = 1'b1;
      if (port) begin
         req1_valid_i = 1'b1; req1_ctl_i = ctl; req1_a_i = a; req1_b_i = b;
      end else begin
         req0_valid_i = 1'b1; req0_ctl_i = ctl; req0_a_i = a; req0_b_i = b;
      end
      #1;
      n = 0;
      while (!(port ? req1_ready_o : req0_ready_o) && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) ok = 1'b0;
      tick();
      mLast = port;
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      n = 1;
      while (!rsp_valid_o && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) ok = 1'b0;
      lat = n;
      d = rsp_data_o; z = rsp_zero_o; id = rsp_id_o; e = rsp_err_o;
      tick();
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b0;
      req0_ctl_i = '0; req0_a_i = '0; req0_b_i = '0;
      req1_ctl_i = '0; req1_a_i = '0; req1_b_i = '0;
      repeat (3) tick();
      nCompared++;
      if ({rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_err_o, req0_ready_o, req1_ready_o} !== 6'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_flags: got %b want 000000",
                  {rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_err_o, req0_ready_o, req1_ready_o});
      end
      nCompared++;
      if (rsp_data_o !== 32'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_data: got %h want 00000000", rsp_data_o);
      end
      rst_i = 1'b1;
      mLast = 1'b1;
      tick();
   endtask

   task automatic test_add();
      rsp_ready_i = 1'b1;
      req0_valid_i = 1'b1; req0_ctl_i = 4'd2; req0_a_i = 32'hFFFFFFFF; req0_b_i = 32'd2;
      #1;
      nCompared++;
      if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
         nMismatched++;
         $display("[TB] FAIL add_ready: got %b want 10", {req0_ready_o, req1_ready_o});
      end
      tick();
      req0_valid_i = 1'b0;
      mLast = 1'b0;
      nCompared++;
      if (rsp_valid_o !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL add_exec_valid: got %b want 0", rsp_valid_o);
      end
      tick();
      nCompared++;
      if ({rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_id_o} !== {1'b1, 32'h00000001, 1'b0, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL add_resp: got v=%b d=%h z=%b id=%b want v=1 d=00000001 z=0 id=0",
                  rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_id_o);
      end
      tick();
      nCompared++;
      if (rsp_valid_o !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL add_release: got %b want 0", rsp_valid_o);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int cnt0 = 0;
      int cnt1 = 0;
      bit g;
      rst_i = 1'b0; #1; rst_i = 1'b1; mLast = 1'b1;
      tick();
      rsp_ready_i = 1'b1;
      req0_valid_i = 1'b1; req0_ctl_i = 4'd6;  req0_a_i = 32'd5; req0_b_i = 32'd5;
      req1_valid_i = 1'b1; req1_ctl_i = 4'd10; req1_a_i = 32'd3; req1_b_i = 32'd7;
      #1;
      for (int k = 0; k < 8; k++) begin
         n = 0;
         while (!(req0_ready_o || req1_ready_o) && n < 10) begin
            tick();
            n++;
         end
         g = req1_ready_o;
         nCompared++;
         if (n >= 10 || g !== k[0]) begin
            nMismatched++;
            $display("[TB] FAIL b2b_grant[%0d]: got %b (wait %0d) want %b", k, g, n, k[0]);
         end
         if (g) cnt1++; else cnt0++;
         tick();
         tick();
         nCompared++;
         if ({rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o} !==
             {1'b1, g, (g ? 32'd21 : 32'd0), !g}) begin
            nMismatched++;
            $display("[TB] FAIL b2b_resp[%0d]: got v=%b id=%b d=%h z=%b want v=1 id=%b d=%h z=%b",
                     k, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, g, (g ? 32'd21 : 32'd0), !g);
         end
         tick();
      end
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      mLast = 1'b1;
      nCompared++;
      if (cnt0 != 4 || cnt1 != 4) begin
         nMismatched++;
         $display("[TB] FAIL b2b_fairness: got %0d/%0d want 4/4", cnt0, cnt1);
      end
   endtask

   task automatic test_shift();
      bit ok; int lat; logic [31:0] d; logic z, id, e;
      issue(1'b1, 4'd3, 32'd40, 32'h80000000, ok, lat, d, z, id, e);
      nCompared++;
      if (!ok || d !== 32'd0 || z !== 1'b1 || id !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL shift_big: got ok=%b d=%h z=%b id=%b want ok=1 d=00000000 z=1 id=1", ok, d, z, id);
      end
      issue(1'b1, 4'd3, 32'd4, 32'h80000000, ok, lat, d, z, id, e);
      nCompared++;
      if (!ok || d !== 32'h08000000 || z !== 1'b0 || lat != 2) begin
         nMismatched++;
         $display("[TB] FAIL shift_4: got ok=%b d=%h z=%b lat=%0d want ok=1 d=08000000 z=0 lat=2", ok, d, z, lat);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      rsp_ready_i = 1'b0;
      req0_valid_i = 1'b1; req0_ctl_i = 4'd1; req0_a_i = 32'h00F0; req0_b_i = 32'h0F00;
      #1;
      tick();
      mLast = 1'b0;
      req0_ctl_i = 4'd7; req0_a_i = 32'd3; req0_b_i = 32'd9;
      tick();
      held = rsp_data_o;
      nCompared++;
      if (held !== 32'h0FF0) begin
         nMismatched++;
         $display("[TB] FAIL bp_data: got %h want 00000ff0", held);
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         nCompared++;
         if ({rsp_valid_o, req0_ready_o, rsp_data_o, rsp_id_o} !== {1'b1, 1'b0, 32'h0FF0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL bp_hold[%0d]: got v=%b rdy0=%b d=%h id=%b want v=1 rdy0=0 d=00000ff0 id=0",
                     k, rsp_valid_o, req0_ready_o, rsp_data_o, rsp_id_o);
         end
      end
      rsp_ready_i = 1'b1;
      #1;
      nCompared++;
      if (req0_ready_o !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL bp_ready_in_resp: got %b want 0", req0_ready_o);
      end
      tick();
      nCompared++;
      if ({rsp_valid_o, req0_ready_o} !== 2'b01) begin
         nMismatched++;
         $display("[TB] FAIL bp_next_accept: got v=%b rdy0=%b want v=0 rdy0=1", rsp_valid_o, req0_ready_o);
      end
      tick();
      req0_valid_i = 1'b0;
      tick();
      nCompared++;
      if ({rsp_valid_o, rsp_data_o, rsp_zero_o} !== {1'b1, 32'd1, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL bp_second: got v=%b d=%h z=%b want v=1 d=00000001 z=0", rsp_valid_o, rsp_data_o, rsp_zero_o);
      end
      tick();
   endtask

   task automatic test_reset_exec();
      rsp_ready_i = 1'b1;
      req0_valid_i = 1'b1; req0_ctl_i = 4'd2; req0_a_i = 32'd1; req0_b_i = 32'd1;
      #1;
      tick();
      req0_valid_i = 1'b0;
      rst_i = 1'b0;
      #1;
      nCompared++;
      if ({rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_err_o, req0_ready_o, req1_ready_o, rsp_data_o} !== 38'd0) begin
         nMismatched++;
         $display("[TB] FAIL rst_exec_outputs: got v=%b id=%b z=%b e=%b r0=%b r1=%b d=%h want all 0",
                  rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_err_o, req0_ready_o, req1_ready_o, rsp_data_o);
      end
      tick();
      rst_i = 1'b1;
      mLast = 1'b1;
      tick();
      nCompared++;
      if (rsp_valid_o !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL rst_exec_no_resp: got %b want 0", rsp_valid_o);
      end
      req0_valid_i = 1'b1; req1_valid_i = 1'b1;
      #1;
      nCompared++;
      if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
         nMismatched++;
         $display("[TB] FAIL rst_exec_tie: got %b want 10", {req0_ready_o, req1_ready_o});
      end
      tick();
      mLast = 1'b0;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_illegal();
      bit ok; int lat; logic [31:0] d; logic z, id, e;
      issue(1'b0, 4'd12, 32'd1, 32'd1, ok, lat, d, z, id, e);
      nCompared++;
      if (!ok || d !== 32'd0 || z !== 1'b1 || e !== ERR_EN) begin
         nMismatched++;
         $display("[TB] FAIL illegal_code: got ok=%b d=%h z=%b err=%b want ok=1 d=00000000 z=1 err=%b", ok, d, z, e, ERR_EN);
      end
      issue(1'b0, 4'd0, 32'hFF00FF00, 32'h0FF00FF0, ok, lat, d, z, id, e);
      nCompared++;
      if (!ok || d !== 32'h0F000F00 || e !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL illegal_clear: got ok=%b d=%h err=%b want ok=1 d=0f000f00 err=0", ok, d, e);
      end
   endtask

   task automatic test_random();
      bit busy = 1'b0;
      bit inResp = 1'b0;
      bit acc0 = 1'b0;
      bit acc1 = 1'b0;
      bit g;
      bit anyV;
      logic [31:0] eData;
      logic eId, eErr;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!req0_valid_i || acc0) begin
            req0_valid_i = ($urandom_range(0, 2) != 0);
            req0_ctl_i = 4'($urandom_range(0, 15));
            req0_a_i = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            req0_b_i = ($urandom_range(0, 5) == 0) ? req0_a_i : $urandom;
         end else if ($urandom_range(0, 7) == 0) begin
            req0_valid_i = 1'b0;
         end
         if (!req1_valid_i || acc1) begin
            req1_valid_i = ($urandom_range(0, 2) != 0);
            req1_ctl_i = 4'($urandom_range(0, 15));
            req1_a_i = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            req1_b_i = ($urandom_range(0, 5) == 0) ? req1_a_i : $urandom;
         end else if ($urandom_range(0, 7) == 0) begin
            req1_valid_i = 1'b0;
         end
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         #1;
         anyV = req0_valid_i || req1_valid_i;
         g = (req0_valid_i && req1_valid_i) ? !mLast : req1_valid_i;
         nCompared++;
         if ({req0_ready_o, req1_ready_o} !== {!busy && anyV && !g, !busy && anyV && g}) begin
            nMismatched++;
            $display("[TB] FAIL rnd_ready[%0d]: got %b want %b", cyc, {req0_ready_o, req1_ready_o},
                     {!busy && anyV && !g, !busy && anyV && g});
         end
         nCompared++;
         if (rsp_valid_o !== (busy && inResp)) begin
            nMismatched++;
            $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", cyc, rsp_valid_o, busy && inResp);
         end
         if (busy && inResp) begin
            nCompared++;
            if ({rsp_data_o, rsp_zero_o, rsp_id_o, rsp_err_o} !== {eData, (eData == 32'd0), eId, eErr}) begin
               nMismatched++;
               $display("[TB] FAIL rnd_resp[%0d]: got d=%h z=%b id=%b e=%b want d=%h z=%b id=%b e=%b", cyc,
                        rsp_data_o, rsp_zero_o, rsp_id_o, rsp_err_o, eData, (eData == 32'd0), eId, eErr);
            end
         end
         acc0 = 1'b0;
         acc1 = 1'b0;
         if (!busy && anyV) begin
            busy = 1'b1; inResp = 1'b0; mLast = g; eId = g;
            if (g) begin
               eData = refAlu(req1_ctl_i, req1_a_i, req1_b_i); eErr = ERR_EN && isIllegal(req1_ctl_i); acc1 = 1'b1;
            end else begin
               eData = refAlu(req0_ctl_i, req0_a_i, req0_b_i); eErr = ERR_EN && isIllegal(req0_ctl_i); acc0 = 1'b1;
            end
         end else if (busy && !inResp) begin
            inResp = 1'b1;
         end else if (busy && rsp_ready_i) begin
            busy = 1'b0;
         end
         @(posedge clk_i);
         #1;
      end
      req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_shift();
      test_backpressure();
      test_reset_exec();
      test_illegal();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
